// File: rtl/anchor_ext_sync_filt.sv
// anchor_ext_sync_filt
// Brings asynchronous external control pins (strobes, triggers, enables) into
// the clk domain. Each channel is optionally inverted, passed through a
// multi-flop synchroniser, then debounced by a stable-for-N-cycles filter.
// Accepted level changes produce registered single-cycle rise/fall pulses.
// Rejected transitions (the synced value returned to the accepted level before
// the filter expired) are summed over all channels into a saturating counter
// for board diagnostics.
module anchor_ext_sync_filt #(
    parameter int unsigned          CHANNELS    = 4,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter int unsigned          FILTER_LEN  = 4,
    parameter logic [CHANNELS-1:0]  INVERT      = {CHANNELS{1'b0}},
    parameter logic [CHANNELS-1:0]  INIT        = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] async_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_out,
    output logic [CHANNELS-1:0] fall_out,
    input  logic                glitch_clr,
    output logic [15:0]         glitch_cnt
);

    // Filter counter width; a FILTER_LEN of 1 still keeps a 1-bit counter
    // that simply never leaves zero.
    localparam int unsigned      CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Number of channels reporting a glitch this cycle (CHANNELS <= 32).
    function automatic logic [5:0] popcount(input logic [CHANNELS-1:0] vec);
        logic [5:0] acc;
        acc = 6'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            acc = acc + {5'd0, vec[i]};
        end
        return acc;
    endfunction

    // 16-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] base,
                                              input logic [5:0]  inc);
        logic [16:0] sum;
        sum = {1'b0, base} + {11'd0, inc};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // Synchroniser chain
    // ------------------------------------------------------------------
    (* ASYNC_REG = "TRUE" *) logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_s;
    logic [CHANNELS-1:0] pin_s;

    // Polarity correction happens before the first flop so INIT and all
    // downstream logic see the post-inversion value.
    assign pin_s  = async_in ^ INVERT;
    assign sync_s = sync_q[SYNC_STAGES-1];

    // Shift the (inverted) pins through the synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= INIT;
            end
        end else begin
            sync_q[0] <= pin_s;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Glitch filter and edge detection
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_q;
    logic [CHANNELS-1:0] fall_d;
    logic [CHANNELS-1:0] glitch_ev_s;

    // Per-channel filter decision: count how long the synced value has
    // disagreed with the accepted level; accept after FILTER_LEN cycles,
    // and flag a glitch if it reverts early.
    always_comb begin
        level_d     = level_q;
        rise_d      = {CHANNELS{1'b0}};
        fall_d      = {CHANNELS{1'b0}};
        glitch_ev_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_s[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    // Held long enough: accept and pulse alongside the new level.
                    level_d[i] = sync_s[i];
                    cnt_d[i]   = CNT_ZERO;
                    rise_d[i]  = sync_s[i];
                    fall_d[i]  = ~sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                if (cnt_q[i] != CNT_ZERO) begin
                    // Returned to the accepted level mid-count: rejected transition.
                    cnt_d[i]       = CNT_ZERO;
                    glitch_ev_s[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end
        end
    end

    // Filter state plus registered level and edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
            level_q <= INIT;
            rise_q  <= {CHANNELS{1'b0}};
            fall_q  <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // ------------------------------------------------------------------
    // Saturating glitch counter
    // ------------------------------------------------------------------
    logic [15:0] glitch_q;
    logic [15:0] glitch_d;

    // Clear has priority: events arriving in the clearing cycle are dropped.
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = 16'h0000;
        end else begin
            glitch_d = sat_add16(glitch_q, popcount(glitch_ev_s));
        end
    end

    // Diagnostic counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= 16'h0000;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign level_out  = level_q;
    assign rise_out   = rise_q;
    assign fall_out   = fall_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_anchor_ext_sync_filt.sv
// Bench for anchor_ext_sync_filt. Three instances cover the default
// configuration (A), inverted/INIT=1 channel 0 (B) and FILTER_LEN=1 with a
// 3-stage synchroniser (C). Stimulus pushes expected level/pulse snapshots
// with their due cycle into per-instance queues; a monitor pops and compares
// whenever an entry is due or a pulse appears.
module tb_anchor_ext_sync_filt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0]       rst_n;
    logic [2:0][3:0]  pin;
    logic [2:0]       clr;
    logic [2:0][3:0]  lvl;
    logic [2:0][3:0]  rs;
    logic [2:0][3:0]  fl;
    logic [2:0][15:0] gc;

    anchor_ext_sync_filt u_a (
        .clk(clk), .rst_n(rst_n[0]), .async_in(pin[0]), .level_out(lvl[0]),
        .rise_out(rs[0]), .fall_out(fl[0]), .glitch_clr(clr[0]), .glitch_cnt(gc[0]));

    anchor_ext_sync_filt #(.INVERT(4'b0001), .INIT(4'b0001)) u_b (
        .clk(clk), .rst_n(rst_n[1]), .async_in(pin[1]), .level_out(lvl[1]),
        .rise_out(rs[1]), .fall_out(fl[1]), .glitch_clr(clr[1]), .glitch_cnt(gc[1]));

    anchor_ext_sync_filt #(.FILTER_LEN(1), .SYNC_STAGES(3)) u_c (
        .clk(clk), .rst_n(rst_n[2]), .async_in(pin[2]), .level_out(lvl[2]),
        .rise_out(rs[2]), .fall_out(fl[2]), .glitch_clr(clr[2]), .glitch_cnt(gc[2]));

    typedef struct {
        int         due;
        logic [3:0] l;
        logic [3:0] r;
        logic [3:0] f;
    } ev_t;

    ev_t sbq [3][$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int due, input logic [3:0] l,
                        input logic [3:0] r, input logic [3:0] f);
        ev_t e;
        e.due = due;
        e.l   = l;
        e.r   = r;
        e.f   = f;
        sbq[d].push_back(e);
    endtask

    // Expect an accepted change: pulse in cycle due, quiet in due+1.
    task automatic push_edge(input int d, input int due, input logic [3:0] l,
                             input logic [3:0] r, input logic [3:0] f);
        push(d, due, l, r, f);
        push(d, due + 1, l, 4'b0000, 4'b0000);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare due entries, flag missed or unexpected pulses.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (sbq[d].size() > 0 && sbq[d][0].due < cyc) begin
                chk($sformatf("sb%0d_missed_due%0d", d, sbq[d][0].due), 16'h0001, 16'h0000);
                void'(sbq[d].pop_front());
            end
            if (sbq[d].size() > 0 && sbq[d][0].due == cyc) begin
                ev_t e;
                e = sbq[d].pop_front();
                chk($sformatf("sb%0d_lvl_rise_fall", d),
                    {4'h0, lvl[d], rs[d], fl[d]}, {4'h0, e.l, e.r, e.f});
            end else if ((rs[d] | fl[d]) != 4'b0000) begin
                chk($sformatf("sb%0d_unexpected_pulse", d),
                    {8'h00, rs[d], fl[d]}, 16'h0000);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n = 3'b000;
        pin   = '0;
        clr   = 3'b000;
        wait_cyc(3);

        // Reset state of every instance.
        chk("rst_a_level", {12'h0, lvl[0]}, 16'h0000);
        chk("rst_a_pulses", {8'h0, rs[0], fl[0]}, 16'h0000);
        chk("rst_a_gcnt", gc[0], 16'h0000);
        chk("rst_b_level", {12'h0, lvl[1]}, 16'h0001);
        chk("rst_c_level", {12'h0, lvl[2]}, 16'h0000);
        rst_n = 3'b111;
        wait_cyc(3);

        // A: ch0 rises, accepted after 2+4 cycles.
        c = cyc; pin[0] = 4'b0001;
        push_edge(0, c + 6, 4'b0001, 4'b0001, 4'b0000);
        wait_cyc(10);

        // A: 3-cycle ch1 pulse is rejected and counted once.
        pin[0] = 4'b0011; wait_cyc(3); pin[0] = 4'b0001; wait_cyc(8);
        chk("a_glitch_3cyc", gc[0], 16'h0001);
        chk("a_level_after_glitch", {12'h0, lvl[0]}, 16'h0001);

        // A: simultaneous 2-cycle pulses on ch1 and ch2.
        pin[0] = 4'b0111; wait_cyc(2); pin[0] = 4'b0001; wait_cyc(8);
        chk("a_glitch_dual", gc[0], 16'h0003);

        // A: ch0 falls.
        c = cyc; pin[0] = 4'b0000;
        push_edge(0, c + 6, 4'b0000, 4'b0000, 4'b0000 | 4'b0001);
        wait_cyc(10);

        // A: reset mid-filter (cnt=3), then full latency after release.
        pin[0] = 4'b0001; wait_cyc(5);
        rst_n[0] = 1'b0; #1;
        chk("a_midrst_level", {12'h0, lvl[0]}, 16'h0000);
        chk("a_midrst_gcnt", gc[0], 16'h0000);
        wait_cyc(2);
        c = cyc; rst_n[0] = 1'b1;
        push_edge(0, c + 6, 4'b0001, 4'b0001, 4'b0000);
        wait_cyc(10);
        chk("a_after_rst_gcnt", gc[0], 16'h0000);

        c = cyc; pin[0] = 4'b0000;
        push_edge(0, c + 6, 4'b0000, 4'b0000, 4'b0001);
        wait_cyc(10);

        // A: drive the counter to 0xFFFE with 1-cycle pulses, then saturate.
        for (int k = 0; k < 16383; k++) begin
            pin[0] = 4'b1111; wait_cyc(1); pin[0] = 4'b0000; wait_cyc(1);
        end
        pin[0] = 4'b0011; wait_cyc(1); pin[0] = 4'b0000; wait_cyc(6);
        chk("a_gcnt_fffe", gc[0], 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            pin[0] = 4'b0001; wait_cyc(1); pin[0] = 4'b0000; wait_cyc(1);
        end
        wait_cyc(6);
        chk("a_gcnt_sat", gc[0], 16'hFFFF);

        // A: clear in the same cycle as a glitch event wins.
        pin[0] = 4'b0001; wait_cyc(1); pin[0] = 4'b0000; wait_cyc(2);
        clr[0] = 1'b1; wait_cyc(1); clr[0] = 1'b0;
        chk("a_clr_same_cycle", gc[0], 16'h0000);
        wait_cyc(4);
        chk("a_clr_dropped", gc[0], 16'h0000);

        // B: inverted ch0 with INIT=1 falls when the pin goes high, rises back.
        c = cyc; pin[1] = 4'b0001;
        push_edge(1, c + 6, 4'b0000, 4'b0000, 4'b0001);
        wait_cyc(10);
        c = cyc; pin[1] = 4'b0000;
        push_edge(1, c + 6, 4'b0001, 4'b0001, 4'b0000);
        wait_cyc(10);
        chk("b_gcnt", gc[1], 16'h0000);

        // C: FILTER_LEN=1, 3 sync stages: ch3 toggles every 2 cycles.
        c = cyc;
        for (int k = 0; k < 6; k++) begin
            if ((k % 2) == 0) begin
                pin[2] = 4'b1000;
                push_edge(2, c + 2 * k + 4, 4'b1000, 4'b1000, 4'b0000);
            end else begin
                pin[2] = 4'b0000;
                push_edge(2, c + 2 * k + 4, 4'b0000, 4'b0000, 4'b1000);
            end
            wait_cyc(2);
        end
        wait_cyc(8);
        chk("c_gcnt", gc[2], 16'h0000);

        // All expectations consumed.
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("sb%0d_drain", d), 16'(sbq[d].size()), 16'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/anchor_ext_sync_filt.md
# anchor_ext_sync_filt

Parametrised multi-channel synchroniser for asynchronous external control pins (EBI strobes, trigger and enable lines) into a single anchor clock domain. It adds three things to plain two-flop synchronisation:
- per-channel polarity inversion,
- a stable-for-N-cycles glitch filter,
- registered rise/fall pulses.

A saturating glitch counter supports board diagnostics. One instance sits at each clock domain that consumes external control.

## Interface
- CHANNELS, 4: number of independent input lines; legal range 1..32.
- SYNC_STAGES, 2: synchroniser depth in flops; legal range 2..4.
- FILTER_LEN, 4: consecutive cycles a new synced value must hold before it is accepted; legal range 1..256; 1 = no filtering.
- INVERT, {CHANNELS{1'b0}}: per-channel mask; bit=1 inverts the pin before synchronisation (active-low pins such as nrde).
- INIT, {CHANNELS{1'b0}}: per-channel reset value of the synchroniser flops and of level_out (post-inversion).
- clk  in  1  destination clock; all logic in this domain.
- rst_n  in  1  asynchronous, active-low reset.
- async_in  in  CHANNELS  raw external pins, asynchronous to clk.
- level_out  out  CHANNELS  filtered, synchronised level (post-inversion).
- rise_out  out  CHANNELS  1-cycle pulse when level_out bit goes 0->1.
- fall_out  out  CHANNELS  1-cycle pulse when level_out bit goes 1->0.
- glitch_clr  in  1  synchronous clear of glitch_cnt.
- glitch_cnt  out  16  saturating count of rejected transitions, summed over all channels.

## Operation
- Per channel i: x[i] = async_in[i] ^ INVERT[i]. x[i] feeds a SYNC_STAGES-deep flop chain whose last stage is s[i].
- Per-channel filter counter cnt[i], width max(1, clog2(FILTER_LEN)). On each edge:
  - s!=level, cnt==FILTER_LEN-1: level<=s, cnt<=0, and rise (s=1) or fall (s=0) pulses next cycle.
  - s!=level, otherwise: cnt<=cnt+1.
  - s==level, cnt!=0: cnt<=0; counts as one glitch event for this channel.
  - s==level, cnt==0: hold.
- FILTER_LEN=1: the first branch is always taken. level follows s with one cycle delay, and no glitches are ever counted.
- rise_out/fall_out are registered and asserted exactly in the cycle where level_out first shows the new value. Never both high on one channel in one cycle.
- glitch_cnt: each cycle add the popcount of this cycle's glitch events.
  - Saturates at 0xFFFF: never wraps, stays there until cleared.
  - glitch_clr=1 loads 0; clear wins over any same-cycle increment, and those events are dropped.
- Channels are fully independent. Simultaneous events on several channels are all processed in the same cycle.

## Timing
- Reset (rst_n low, async assert):
  - sync flops = INIT, level_out = INIT, all cnt = 0.
  - rise_out = 0, fall_out = 0, glitch_cnt = 0.
- Release of rst_n must be synchronised externally to clk.
- No edge pulses after reset even if async_in differs from INIT. Any difference is filtered like a normal transition and produces one pulse once accepted.
- Latency from the first clk edge that samples a new pin value to level_out/pulse change: SYNC_STAGES + FILTER_LEN cycles (defaults: 2+4 = 6). Uncertainty is one extra cycle from metastability resolution.
- Minimum accepted pulse width at the pin: FILTER_LEN clk periods. Anything shorter that reaches s is rejected and counted.
- Reset mid-filter: cnt is discarded, no pulse is issued, and no glitch is counted.
- glitch_cnt updates one cycle after the glitch-ending s edge.
- Synchroniser flops carry the ASYNC_REG attribute. async_in is a false-path input.

## Test plan
- Defaults, reset with async_in=0: after rst_n release, drive ch0 high and hold -> level_out[0]=1 and rise_out[0] single-cycle pulse 6 cycles after the first sampling edge; no other outputs move.
- INVERT=4'b0001, INIT=4'b0001, async_in=0 through reset -> level_out=4'b0001 with no pulses. Pin ch0 high for 10 cycles -> fall_out[0] pulse at cycle 6, level_out[0]=0.
- Defaults: pulse ch1 high for 3 cycles -> no level change, no rise/fall, glitch_cnt=1. Pulse ch1 and ch2 high for 2 cycles in the same cycles -> glitch_cnt=3.
- FILTER_LEN=1, SYNC_STAGES=3: toggle ch3 every 2 cycles -> level_out[3] tracks the pin with 4-cycle latency, alternating rise/fall pulses, glitch_cnt stays 0.
- Preload glitch_cnt to 0xFFFE via 2 glitches on top of a forced count, then 3 more glitches -> holds 0xFFFF. Assert glitch_clr in the same cycle as a glitch -> glitch_cnt=0.
- ch0 high for 3 cycles post-sync (cnt=3), assert rst_n low -> level_out=INIT, cnt cleared, no pulse. After release with pin still high -> a rise pulse after the full 6-cycle latency.
